// File: rtl/aes_pkg.sv
// Shared AES control definitions: state-mux selector encodings, FSM state
// codes for both binary and sparse builds, and the legal round counts.
package aes_pkg;

  localparam int Mux3SelWidth = 5;

  typedef enum logic [Mux3SelWidth-1:0] {
    SEL_INIT  = 5'b01110,
    SEL_ROUND = 5'b11000,
    SEL_CLEAR = 5'b00001
  } mux3_sel_e;

  // Sparse codes keep a Hamming distance of at least 3 between any two states
  localparam logic [5:0] ST_SP_IDLE  = 6'b011101;
  localparam logic [5:0] ST_SP_INIT  = 6'b110000;
  localparam logic [5:0] ST_SP_ROUND = 6'b001000;
  localparam logic [5:0] ST_SP_CLEAR = 6'b000011;
  localparam logic [5:0] ST_SP_ERROR = 6'b111110;

  localparam logic [2:0] ST_BIN_IDLE  = 3'd0;
  localparam logic [2:0] ST_BIN_INIT  = 3'd1;
  localparam logic [2:0] ST_BIN_ROUND = 3'd2;
  localparam logic [2:0] ST_BIN_CLEAR = 3'd3;
  localparam logic [2:0] ST_BIN_ERROR = 3'd4;

  localparam logic [31:0] NumRoundsAes128 = 32'd10;
  localparam logic [31:0] NumRoundsAes192 = 32'd12;
  localparam logic [31:0] NumRoundsAes256 = 32'd14;

  function automatic logic rounds_legal(input logic [31:0] n);
    return (n == NumRoundsAes128) || (n == NumRoundsAes192) ||
           (n == NumRoundsAes256);
  endfunction

endpackage

// File: rtl/aes_state_sel_fsm_if.sv
// Handshake bundle between the AES state-select FSM (slave) and its parent
// (master): start/clear control, datapath round handshake, selector, status.
interface aes_state_sel_fsm_if
  import aes_pkg::*;
#(
  parameter int RoundCntW = 4
);
  logic                    start_i;
  logic [RoundCntW-1:0]    num_rounds_i;
  logic                    clear_i;
  logic                    round_req_o;
  logic                    round_ack_i;
  logic [Mux3SelWidth-1:0] sel_o;
  logic                    sel_err_i;
  logic                    ready_o;
  logic                    done_o;
  logic [RoundCntW-1:0]    round_o;
  logic                    alert_o;

  modport slave (
    input  start_i, num_rounds_i, clear_i, round_ack_i, sel_err_i,
    output round_req_o, sel_o, ready_o, done_o, round_o, alert_o
  );

  modport master (
    output start_i, num_rounds_i, clear_i, round_ack_i, sel_err_i,
    input  round_req_o, sel_o, ready_o, done_o, round_o, alert_o
  );
endinterface

// File: rtl/aes_state_sel_fsm.sv
// AES state-mux sequencing FSM: IDLE -> INIT -> N x ROUND -> CLEAR, terminal
// ERROR with sticky alert. AES_STATE_SEL_FSM_SPARSE_EN selects sparse state codes.
module aes_state_sel_fsm
  import aes_pkg::*;
#(
  parameter int RoundCntW = 4,
  parameter bit ChkSel    = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  aes_state_sel_fsm_if.slave  bus
);

`ifdef AES_STATE_SEL_FSM_SPARSE_EN
  typedef enum logic [5:0] {
    IDLE  = ST_SP_IDLE,
    INIT  = ST_SP_INIT,
    ROUND = ST_SP_ROUND,
    CLEAR = ST_SP_CLEAR,
    ERROR = ST_SP_ERROR
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = ST_BIN_IDLE,
    INIT  = ST_BIN_INIT,
    ROUND = ST_BIN_ROUND,
    CLEAR = ST_BIN_CLEAR,
    ERROR = ST_BIN_ERROR
  } state_e;
`endif

  state_e                  r_state;
  logic                    r_finish;
  logic [RoundCntW-1:0]    r_num_rounds;
  logic [Mux3SelWidth-1:0] r_sel;
  logic                    r_req;
  logic                    r_ready;
  logic                    r_done;
  logic [RoundCntW-1:0]    r_round;
  logic                    r_alert;

  logic w_bad_state;
  logic w_last;
  logic w_to_err;

`ifdef AES_STATE_SEL_FSM_SPARSE_EN
  assign w_bad_state = !(r_state inside {IDLE, INIT, ROUND, CLEAR, ERROR});
`else
  assign w_bad_state = 1'b0;
`endif

  assign w_last   = (r_round == (r_num_rounds - RoundCntW'(1)));
  assign w_to_err = (ChkSel && bus.sel_err_i) || w_bad_state ||
                    ((r_state == IDLE) && bus.start_i &&
                     !rounds_legal(32'(bus.num_rounds_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_finish <= 1'b0;
      r_sel    <= SEL_CLEAR;
      r_req    <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_round  <= '0;
      r_alert  <= 1'b0;
    end else if (w_to_err) begin
      r_state <= ERROR;
      r_sel   <= SEL_CLEAR;
      r_req   <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_alert <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_done   <= 1'b0;
          r_finish <= 1'b0;
          if (bus.start_i) begin
            r_num_rounds <= bus.num_rounds_i;
            r_state      <= INIT;
            r_sel        <= SEL_INIT;
            r_ready      <= 1'b0;
            r_round      <= '0;
          end
        end
        INIT: begin
          if (bus.clear_i) begin
            r_state  <= CLEAR;
            r_sel    <= SEL_CLEAR;
            r_finish <= 1'b0;
          end else begin
            r_state <= ROUND;
            r_sel   <= SEL_ROUND;
            r_req   <= 1'b1;
          end
        end
        ROUND: begin
          // An abort drops any ack arriving in the same cycle
          if (bus.clear_i) begin
            r_state  <= CLEAR;
            r_sel    <= SEL_CLEAR;
            r_req    <= 1'b0;
            r_finish <= 1'b0;
          end else if (bus.round_ack_i) begin
            r_round <= r_round + 1'b1;
            if (w_last) begin
              r_state  <= CLEAR;
              r_sel    <= SEL_CLEAR;
              r_req    <= 1'b0;
              r_finish <= 1'b1;
            end
          end
        end
        CLEAR: begin
          r_state  <= IDLE;
          r_sel    <= SEL_CLEAR;
          r_ready  <= 1'b1;
          r_done   <= r_finish;
          r_finish <= 1'b0;
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state  <= IDLE;
          r_sel    <= SEL_CLEAR;
          r_req    <= 1'b0;
          r_ready  <= 1'b1;
          r_done   <= 1'b0;
          r_finish <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_o       = r_sel;
  assign bus.round_req_o = r_req;
  assign bus.ready_o     = r_ready;
  assign bus.done_o      = r_done;
  assign bus.round_o     = r_round;
  assign bus.alert_o     = r_alert;

endmodule

// File: tb/tb_aes_state_sel_fsm.sv
// Directed bench for aes_state_sel_fsm: full runs, wait states, abort,
// selector error, illegal round count and start/error priority.
module tb_aes_state_sel_fsm;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   n_done;

  aes_state_sel_fsm_if #(.RoundCntW(4)) bus ();

  aes_state_sel_fsm #(.RoundCntW(4), .ChkSel(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.done_o === 1'b1) n_done++;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] sel,
                            input logic req, input logic rdy, input logic done,
                            input logic [3:0] rnd, input logic alert);
    check_val({tag, ".sel"},   32'(bus.sel_o),       32'(sel));
    check_val({tag, ".req"},   32'(bus.round_req_o), 32'(req));
    check_val({tag, ".ready"}, 32'(bus.ready_o),     32'(rdy));
    check_val({tag, ".done"},  32'(bus.done_o),      32'(done));
    check_val({tag, ".round"}, 32'(bus.round_o),     32'(rnd));
    check_val({tag, ".alert"}, 32'(bus.alert_o),     32'(alert));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    n_done   = 0;
    rst = 1'b1;
    bus.start_i      = 1'b0;
    bus.num_rounds_i = 4'd0;
    bus.clear_i      = 1'b0;
    bus.round_ack_i  = 1'b0;
    bus.sel_err_i    = 1'b0;

    // Reset state
    do_reset();
    check_outs("reset", 5'b00001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // 10 rounds, ack every cycle
    bus.start_i = 1'b1; bus.num_rounds_i = 4'd10; bus.round_ack_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    check_outs("r10_init", 5'b01110, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      check_outs($sformatf("r10_round%0d", k), 5'b11000, 1'b1, 1'b0, 1'b0,
                 4'(k), 1'b0);
    end
    step();
    check_outs("r10_clear", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0);
    step();
    check_outs("r10_done", 5'b00001, 1'b0, 1'b1, 1'b1, 4'd10, 1'b0);
    bus.round_ack_i = 1'b0;
    step();
    check_val("r10_done_pulse", 32'(bus.done_o), 32'd0);

    // 14 rounds, 3 wait cycles before each ack
    n_done = 0;
    bus.start_i = 1'b1; bus.num_rounds_i = 4'd14;
    step();
    bus.start_i = 1'b0;
    check_outs("r14_init", 5'b01110, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    for (int r = 0; r < 14; r++) begin
      for (int w = 0; w < 3; w++) begin
        step();
        check_val($sformatf("r14_wait_req%0d", r), 32'(bus.round_req_o), 32'd1);
        check_val($sformatf("r14_wait_rnd%0d", r), 32'(bus.round_o), 32'(r));
      end
      bus.round_ack_i = 1'b1;
      step();
      bus.round_ack_i = 1'b0;
      check_val($sformatf("r14_ack_rnd%0d", r), 32'(bus.round_o), 32'(r + 1));
    end
    check_outs("r14_clear", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd14, 1'b0);
    step();
    check_outs("r14_done", 5'b00001, 1'b0, 1'b1, 1'b1, 4'd14, 1'b0);
    step();
    step();
    check_val("r14_done_count", 32'(n_done), 32'd1);

    // Abort in round 5 with a coincident ack
    n_done = 0;
    bus.start_i = 1'b1; bus.num_rounds_i = 4'd10; bus.round_ack_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    for (int k = 0; k < 5; k++) step();
    check_val("abort_at_round", 32'(bus.round_o), 32'd5);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0; bus.round_ack_i = 1'b0;
    check_outs("abort_clear", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
    step();
    check_outs("abort_idle", 5'b00001, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
    step();
    check_val("abort_no_done", 32'(n_done), 32'd0);
    bus.start_i = 1'b1; bus.num_rounds_i = 4'd12;
    step();
    bus.start_i = 1'b0;
    check_outs("restart_init", 5'b01110, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    check_outs("init_clear", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    check_outs("init_clear_idle", 5'b00001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // Selector error during ROUND
    bus.start_i = 1'b1; bus.num_rounds_i = 4'd10;
    step();
    bus.start_i = 1'b0;
    step();
    check_val("err_in_round", 32'(bus.sel_o), 32'(5'b11000));
    bus.sel_err_i = 1'b1;
    step();
    bus.sel_err_i = 1'b0;
    check_outs("err_entry", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    bus.start_i = 1'b1;
    step();
    step();
    bus.start_i = 1'b0;
    check_outs("err_sticky", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    do_reset();
    check_outs("err_reset", 5'b00001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // Illegal round count
    bus.start_i = 1'b1; bus.num_rounds_i = 4'd11;
    step();
    bus.start_i = 1'b0;
    check_outs("illegal_nr", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    do_reset();

    // Legal start coinciding with a selector error
    bus.start_i = 1'b1; bus.num_rounds_i = 4'd10; bus.sel_err_i = 1'b1;
    step();
    bus.start_i = 1'b0; bus.sel_err_i = 1'b0;
    check_outs("prio_err", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    do_reset();

`ifdef AES_STATE_SEL_FSM_SPARSE_EN
    // Corrupted state register
    force dut.r_state = 6'b000000;
    step();
    release dut.r_state;
    check_outs("bad_state", 5'b00001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
